// File: rtl/ipml_prefetch_sfifo_pkg.sv
// ipml_prefetch_sfifo_pkg
//   Shared sizing helpers for the single-clock prefetch FIFO family.
//   out_depth()   : number of output-stage registers for a given RAM output mode
//   level_width() : width of the level counter for a given RAM address width
//   capacity()    : total words the FIFO can hold (RAM plus output stage)
package ipml_prefetch_sfifo_pkg;

  // With a RAM output register the read pipe is one stage longer, so the
  // output stage needs one more slot to keep one word per cycle flowing.
  function automatic int out_depth(input int ram_out_reg);
    return (ram_out_reg != 0) ? 3 : 2;
  endfunction

  // Level must represent 0 .. 2^aw + 3.
  function automatic int level_width(input int aw);
    return aw + 2;
  endfunction

  function automatic int capacity(input int aw, input int ram_out_reg);
    return (1 << aw) + out_depth(ram_out_reg);
  endfunction

endpackage

// File: rtl/ipml_out_reg_fifo_v2_0.sv
// ipml_out_reg_fifo_v2_0
//   Small in-order register FIFO used as the prefetch output stage.
//   Entry 0 is always the head; a pop shifts the array down by one.
//   Ports:
//     clk, rst         clock, asynchronous active-high reset
//     in_vld, in_data  incoming word; always accepted (caller guarantees space)
//     out_rdy          consumer ready; pop = out_vld & out_rdy
//     out_vld          head entry is valid
//     out_data         head entry (reset value 0)
//     cnt              number of occupied entries
module ipml_out_reg_fifo_v2_0
  import ipml_prefetch_sfifo_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  input  logic [W-1:0]                 in_data,
  input  logic                         out_rdy,
  output logic                         out_vld,
  output logic [W-1:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  regs [DEPTH];
  logic          pop;
  logic [CW-1:0] wr_idx;

  assign out_vld  = (cnt != '0);
  assign out_data = regs[0];
  assign pop      = out_vld & out_rdy;
  // A simultaneous pop frees the head, so the new word lands one slot lower.
  assign wr_idx   = cnt - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (pop) regs[i] <= regs[i+1];
      end
      // Later assignment wins over the shift for the written slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (in_vld && (wr_idx == CW'(i))) regs[i] <= in_data;
      end
      cnt <= cnt + CW'(in_vld) - CW'(pop);
    end
  end

endmodule

// File: rtl/ipml_prefetch_sfifo_v2_0.sv
// ipml_prefetch_sfifo_v2_0
//   Single-clock first-word-fall-through FIFO: inferred simple-dual-port RAM
//   with registered read, followed by a 2-entry (3 with c_RAM_OUT_REG=1)
//   register output stage giving zero read latency to the consumer.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     wr_data, wr_en write word / request
//     wr_vld         space available (registered); push = wr_en & wr_vld
//     rd_data        head-of-FIFO word, valid when rd_vld
//     rd_en          consumer ready; pop = rd_vld & rd_en
//     rd_vld         rd_data valid
//     level          words held (RAM + in flight + output stage)
//     almost_full    level >= c_AF_LEVEL (registered)
//     almost_empty   level <= c_AE_LEVEL (registered)
//   Optional (macro IPML_PREFETCH_SFIFO_ERR_EN):
//     wr_ovf         sticky: write attempted while wr_vld=0
//     rd_udf         sticky: read attempted while rd_vld=0
//   Handshake: a transfer happens on a rising edge where valid and ready/en
//   are both high; valid never depends combinationally on the partner's en.
module ipml_prefetch_sfifo_v2_0
  import ipml_prefetch_sfifo_pkg::*;
#(
  parameter int c_DATA_WIDTH  = 16,
  parameter int c_DEPTH_WIDTH = 10,
  parameter int c_AF_LEVEL    = 1020,
  parameter int c_AE_LEVEL    = 4,
  parameter int c_RAM_OUT_REG = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [c_DATA_WIDTH-1:0]    wr_data,
  input  logic                       wr_en,
  output logic                       wr_vld,
  output logic [c_DATA_WIDTH-1:0]    rd_data,
  input  logic                       rd_en,
  output logic                       rd_vld,
  output logic [c_DEPTH_WIDTH+1:0]   level,
  output logic                       almost_full,
  output logic                       almost_empty
`ifdef IPML_PREFETCH_SFIFO_ERR_EN
  ,
  output logic                       wr_ovf,
  output logic                       rd_udf
`endif
);

  localparam int OUT_DEPTH = out_depth(c_RAM_OUT_REG);
  localparam int RAM_LAT   = (c_RAM_OUT_REG != 0) ? 2 : 1;
  localparam int LW        = level_width(c_DEPTH_WIDTH);
  localparam int RAM_WORDS = 1 << c_DEPTH_WIDTH;
  localparam int OCW       = $clog2(OUT_DEPTH + 1);
  localparam logic [c_DEPTH_WIDTH:0] RAM_FULL = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
  localparam logic [LW-1:0] AF_L = LW'(c_AF_LEVEL);
  localparam logic [LW-1:0] AE_L = LW'(c_AE_LEVEL);

  logic [c_DATA_WIDTH-1:0]  mem [RAM_WORDS];
  logic [c_DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [c_DEPTH_WIDTH:0]   ram_cnt;
  logic [1:0]               infl;       // read-issue pipe; bit 1 used only with RAM output reg
  logic [1:0]               infl_cnt;
  logic [c_DATA_WIDTH-1:0]  ram_q;
  logic [c_DATA_WIDTH-1:0]  ret_data;
  logic                     ret_vld;
  logic [OCW-1:0]           out_cnt;
  logic [3:0]               commit;
  logic                     push, pop, issue;
  logic [LW-1:0]            level_nxt;

  assign wr_vld    = (ram_cnt != RAM_FULL);
  assign push      = wr_en & wr_vld;
  assign pop       = rd_vld & rd_en;
  assign infl_cnt  = {1'b0, infl[0]} + {1'b0, infl[1]};
  // Words that will occupy the output stage once everything in flight lands.
  assign commit    = 4'(out_cnt) + 4'(infl_cnt) - 4'(pop);
  assign issue     = (ram_cnt != '0) && (commit < 4'(OUT_DEPTH));
  assign ret_vld   = infl[RAM_LAT-1];
  assign level_nxt = level + LW'(push) - LW'(pop);

  // RAM: no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (push)  mem[wr_ptr] <= wr_data;
    if (issue) ram_q <= mem[rd_ptr];
  end

  generate
    if (c_RAM_OUT_REG != 0) begin : g_ram_oreg
      logic [c_DATA_WIDTH-1:0] ram_q2;
      always_ff @(posedge clk) ram_q2 <= ram_q;
      assign ret_data = ram_q2;
    end else begin : g_ram_direct
      assign ret_data = ram_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      infl         <= '0;
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt      <= ram_cnt + {{c_DEPTH_WIDTH{1'b0}}, push}
                              - {{c_DEPTH_WIDTH{1'b0}}, issue};
      infl[0]      <= issue;
      infl[1]      <= (RAM_LAT == 2) ? infl[0] : 1'b0;
      level        <= level_nxt;
      almost_full  <= (level_nxt >= AF_L);
      almost_empty <= (level_nxt <= AE_L);
    end
  end

  ipml_out_reg_fifo_v2_0 #(
    .W     (c_DATA_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (ret_vld),
    .in_data  (ret_data),
    .out_rdy  (rd_en),
    .out_vld  (rd_vld),
    .out_data (rd_data),
    .cnt      (out_cnt)
  );

`ifdef IPML_PREFETCH_SFIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ovf <= 1'b0;
      rd_udf <= 1'b0;
    end else begin
      if (wr_en && !wr_vld) wr_ovf <= 1'b1;
      if (rd_en && !rd_vld) rd_udf <= 1'b1;
    end
  end
`else
  // Error flags are not built; misuse is silently ignored.
`endif

endmodule
